// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus four-state debounce filter for a raw board switch.
// Clean level, one-cycle edge strobes and a saturating count of aborted transitions.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int BOUNCE_W        = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_sw,
    output logic                o_sw,
    output logic                o_rise,
    output logic                o_fall,
    output logic [BOUNCE_W-1:0] o_bounce_cnt
);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BOUNCE_W-1:0] BOUNCE_ONE = BOUNCE_W'(1);
    localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sw;
    logic                r_rise;
    logic                r_fall;
    logic [BOUNCE_W-1:0] r_bounce;
    logic                w_s;
    logic [BOUNCE_W-1:0] w_bounce_inc;

    assign w_s          = r_sync2;
    assign w_bounce_inc = (r_bounce == BOUNCE_MAX) ? r_bounce : r_bounce + BOUNCE_ONE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= STABLE_LO;
            r_cnt    <= '0;
            r_sw     <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_bounce <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= CHK_HI;
                        r_cnt   <= CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        r_state  <= STABLE_LO;
                        r_cnt    <= '0;
                        r_bounce <= w_bounce_inc;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_sw    <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= CHK_LO;
                        r_cnt   <= CNT_ONE;
                    end
                end
                CHK_LO: begin
                    // Mirror of CHK_HI: a 1 sample aborts back to the high level.
                    if (w_s) begin
                        r_state  <= STABLE_HI;
                        r_cnt    <= '0;
                        r_bounce <= w_bounce_inc;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_sw    <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_sw         = r_sw;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_bounce_cnt = r_bounce;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two instances (short filter with 2-bit counter, default filter)
// share one stimulus stream and are checked every cycle against a run-length model.
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_in = 1'b0;
    logic       sw_a, rise_a, fall_a;
    logic [1:0] bc_a;
    logic       sw_b, rise_b, fall_b;
    logic [7:0] bc_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sw_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .BOUNCE_W(2)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_sw(sw_in),
        .o_sw(sw_a), .o_rise(rise_a), .o_fall(fall_a), .o_bounce_cnt(bc_a)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(16), .CNT_W(16), .BOUNCE_W(8)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_sw(sw_in),
        .o_sw(sw_b), .o_rise(rise_b), .o_fall(fall_b), .o_bounce_cnt(bc_b)
    );

    logic       obs_sw[2];
    logic       obs_rise[2];
    logic       obs_fall[2];
    logic [7:0] obs_bc[2];

    always_comb begin
        obs_sw[0]   = sw_a;   obs_sw[1]   = sw_b;
        obs_rise[0] = rise_a; obs_rise[1] = rise_b;
        obs_fall[0] = fall_a; obs_fall[1] = fall_b;
        obs_bc[0]   = {6'd0, bc_a};
        obs_bc[1]   = bc_b;
    end

    // Reference: debounced level flips once D consecutive synchronised samples disagree with it;
    // a disagreeing run cut short by an agreeing sample counts as one bounce.
    int   m_d[2]   = '{4, 16};
    int   m_max[2] = '{3, 255};
    logic m_lvl[2];
    int   m_run[2];
    int   m_bc[2];
    logic m_rise[2];
    logic m_fall[2];
    logic m_s1, m_s2;

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1'b0; m_run[k] = 0; m_bc[k] = 0;
            m_rise[k] = 1'b0; m_fall[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic v);
        logic s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = v;
        for (int k = 0; k < 2; k++) begin
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == m_d[k]) begin
                    m_lvl[k] = s;
                    m_run[k] = 0;
                    if (s) m_rise[k] = 1'b1;
                    else   m_fall[k] = 1'b1;
                end
            end else if (m_run[k] > 0) begin
                m_run[k] = 0;
                if (m_bc[k] < m_max[k]) m_bc[k]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sw[%0d]", k),   32'(obs_sw[k]),   32'(m_lvl[k]));
            chk($sformatf("rise[%0d]", k), 32'(obs_rise[k]), 32'(m_rise[k]));
            chk($sformatf("fall[%0d]", k), 32'(obs_fall[k]), 32'(m_fall[k]));
            chk($sformatf("bcnt[%0d]", k), 32'(obs_bc[k]),   32'(m_bc[k]));
            chk($sformatf("excl[%0d]", k), 32'(obs_rise[k] & obs_fall[k]), 32'(0));
        end
    endtask

    // Drive one sample, advance one rising edge, then compare just after it.
    task automatic step(input logic v);
        sw_in = v;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(v);
        #1;
        check_all();
    endtask

    task automatic run_until(input int k, input logic lvl, input logic v, input int start, output int n);
        n = start;
        for (int i = 0; i < 40; i++) begin
            if (obs_sw[k] === lvl) break;
            step(v);
            n++;
        end
    endtask

    int n;
    int exp_sat[6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        model_reset();
        // Reset held three cycles with the switch already high.
        sw_in = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("rst_sw_a", 32'(sw_a), 32'(0));
        chk("rst_bc_b", 32'(bc_b), 32'(0));
        rst_n = 1'b1;
        run_until(0, 1'b1, 1'b1, 0, n);
        chk("rise_edge_a", 32'(n), 32'(6));
        run_until(1, 1'b1, 1'b1, n, n);
        chk("rise_edge_b", 32'(n), 32'(18));

        // Clean fall from stable high.
        run_until(0, 1'b0, 1'b0, 0, n);
        chk("fall_edge_a", 32'(n), 32'(6));
        run_until(1, 1'b0, 1'b0, n, n);
        chk("fall_edge_b", 32'(n), 32'(18));
        step(1'b0);

        // Bounce: two short high pulses, both aborted.
        for (int i = 0; i < 8; i++) step(i[1] ? 1'b0 : 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("bounce_cnt_a", 32'(bc_a), 32'(2));
        chk("bounce_sw_a", 32'(sw_a), 32'(0));

        // Threshold: 3 high samples abort, 4 complete.
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("thresh3_cnt_a", 32'(bc_a), 32'(3));
        chk("thresh3_sw_a", 32'(sw_a), 32'(0));
        for (int i = 0; i < 4; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("thresh4_sw_a", 32'(sw_a), 32'(1));
        for (int i = 0; i < 24; i++) step(1'b0);

        // Saturation of the 2-bit counter.
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("sat_%0d", j), 32'(bc_a), 32'(exp_sat[j]));
            step(1'b1); step(1'b1);
            for (int i = 0; i < 4; i++) step(1'b0);
        end
        chk("sat_final", 32'(bc_a), 32'(3));

        // Asynchronous reset in CHK_HI with cnt=10 on the long filter, then full restart.
        for (int i = 0; i < 12; i++) step(1'b1);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_sw_a", 32'(sw_a), 32'(0));
        chk("mid_rst_bc_a", 32'(bc_a), 32'(0));
        chk("mid_rst_bc_b", 32'(bc_b), 32'(0));
        chk("mid_rst_sw_b", 32'(sw_b), 32'(0));
        step(1'b1);
        rst_n = 1'b1;
        run_until(1, 1'b1, 1'b1, 0, n);
        chk("restart_edge_b", 32'(n), 32'(18));
        chk("restart_bc_b", 32'(bc_b), 32'(0));

        // Random runs of varying length.
        for (int r = 0; r < 60; r++) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
